// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RV32I hazard sequencer: forwarding selects,
// sequencer states and the ResultSrc encoding that marks a load.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_W   = 2'b01,
      FWD_M   = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      FAULT    = 2'b10
   } seq_state_e;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // x0 is hardwired to zero, so a write to it never produces a forwardable value.
   function automatic logic reg_match(input logic [4:0] rd, input logic wr, input logic [4:0] rs);
      return wr && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_sequencer_forwarding_unit.sv
// Combinational operand-forwarding select for one ALU source in E.
// The M stage holds the younger result, so it wins over W.
module forwarding_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic       reg_write_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_w,
   output logic [1:0] fwd_sel
);

   always_comb begin
      fwd_sel = FWD_REG;
      if (reg_match(rd_m, reg_write_m, rs_e)) begin
         fwd_sel = FWD_M;
      end else if (reg_match(rd_w, reg_write_w, rs_e)) begin
         fwd_sel = FWD_W;
      end else begin
         fwd_sel = FWD_REG;
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard and stall sequencer: forwarding, load-use and control-flow hazards,
// a data-memory wait FSM with timeout fault, and saturating perf counters.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic [1:0]       result_src_e,
   input  logic [4:0]       rd_m,
   input  logic             reg_write_m,
   input  logic [4:0]       rd_w,
   input  logic             reg_write_w,
   input  logic             pc_src_e,
   input  logic             mem_access_m,
   input  logic             dmem_ready,
   output logic [1:0]       forward_a_e,
   output logic [1:0]       forward_b_e,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             bubble_w,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int               WCW       = $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0]   WAIT_ONE  = WCW'(1);
   localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   seq_state_e     state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           fault_q, fault_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [1:0] fwd_a_s, fwd_b_s;
   logic       lu_s, ms_s;

   forwarding_unit u_fwd_a (
      .rs_e        (rs1_e),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .fwd_sel     (fwd_a_s)
   );

   forwarding_unit u_fwd_b (
      .rs_e        (rs2_e),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .fwd_sel     (fwd_b_s)
   );

   assign lu_s = (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
                 ((rd_e == rs1_d) || (rd_e == rs2_d));

   // Memory-stall condition; an undefined state encoding freezes the pipe like FAULT.
   always_comb begin
      ms_s = 1'b0;
      case (state_q)
         RUN:      ms_s = mem_access_m && !dmem_ready;
         MEM_WAIT: ms_s = !dmem_ready;
         FAULT:    ms_s = 1'b1;
         default:  ms_s = 1'b1;
      endcase
   end

   // State, wait counter and sticky fault register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
      end
   end

   // Wait FSM next state: FAULT is absorbing until reset.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      fault_d    = fault_q;
      case (state_q)
         RUN: begin
            if (mem_access_m && !dmem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_ONE;
            end else begin
               state_d    = RUN;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q < WAIT_LAST) begin
               wait_cnt_d = wait_cnt_q + WAIT_ONE;
            end else begin
               state_d    = FAULT;
               fault_d    = 1'b1;
            end
         end
         FAULT: begin
            state_d = FAULT;
            fault_d = 1'b1;
         end
         default: begin
            state_d = FAULT;
            fault_d = 1'b1;
         end
      endcase
   end

   // Pipeline control outputs in priority order; reset forces nops into D and E.
   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      bubble_w = 1'b0;
      if (rst) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (ms_s) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         stall_e  = 1'b1;
         stall_m  = 1'b1;
         bubble_w = 1'b1;
      end else if (pc_src_e) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (lu_s) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end else begin
         stall_f = 1'b0;
      end
   end

   // Forward selects are neutral while in reset.
   always_comb begin
      if (rst) begin
         forward_a_e = FWD_REG;
         forward_b_e = FWD_REG;
      end else begin
         forward_a_e = fwd_a_s;
         forward_b_e = fwd_b_s;
      end
   end

   // Saturating counter next values.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_f && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (pc_src_e && !ms_s && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_fault    = fault_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with TIMEOUT=4 and 4-bit counters so
// timeout and counter saturation are reachable in a short run.
module tb_hazard_sequencer;

   localparam logic [6:0] CTL_IDLE = 7'b0000000;
   localparam logic [6:0] CTL_RST  = 7'b0000110;
   localparam logic [6:0] CTL_BR   = 7'b0000110;
   localparam logic [6:0] CTL_LU   = 7'b1100010;
   localparam logic [6:0] CTL_MS   = 7'b1111001;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [1:0] result_src_e;
   logic       reg_write_m, reg_write_w, pc_src_e, mem_access_m, dmem_ready;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w, mem_fault;
   logic [3:0] stall_cycles, flush_count;
   logic [6:0] ctl;

   int total = 0;
   int bad   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 clk = ~clk;

   assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w};

   hazard_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .result_src_e(result_src_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
      .mem_access_m(mem_access_m), .dmem_ready(dmem_ready),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .bubble_w(bubble_w), .mem_fault(mem_fault),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle;
      rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
      result_src_e = 2'b00; rd_m = 5'd0; reg_write_m = 1'b0; rd_w = 5'd0;
      reg_write_w = 1'b0; pc_src_e = 1'b0; mem_access_m = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
      chk({tag, "_flush_count"}, 32'(flush_count), 32'(exp_flush));
   endtask

   initial begin
      idle();
      rst = 1'b1;
      // Reset: forwarding candidates present but selects must stay 00
      rd_m = 5'd5; reg_write_m = 1'b1; rs1_e = 5'd5; rs2_e = 5'd5;
      @(negedge clk);
      chk("rst_ctl", 32'(ctl), 32'(CTL_RST));
      chk("rst_fwd_a", 32'(forward_a_e), 32'(2'b00));
      chk("rst_fwd_b", 32'(forward_b_e), 32'(2'b00));
      step();
      step();
      rst = 1'b0;
      idle();
      @(negedge clk);
      chk("post_rst_ctl", 32'(ctl), 32'(CTL_IDLE));
      chk("post_rst_fault", 32'(mem_fault), 32'd0);
      chk_counters("post_rst");
      step();

      // Forwarding: M beats W
      rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1; rs1_e = 5'd5; rs2_e = 5'd5;
      @(negedge clk);
      chk("fwd_a_m", 32'(forward_a_e), 32'(2'b10));
      chk("fwd_b_m", 32'(forward_b_e), 32'(2'b10));
      chk("fwd_ctl", 32'(ctl), 32'(CTL_IDLE));
      step();
      reg_write_m = 1'b0;
      @(negedge clk);
      chk("fwd_a_w", 32'(forward_a_e), 32'(2'b01));
      chk("fwd_b_w", 32'(forward_b_e), 32'(2'b01));
      step();
      reg_write_m = 1'b1; rd_m = 5'd0; rs1_e = 5'd0; rs2_e = 5'd6; rd_w = 5'd6;
      @(negedge clk);
      chk("fwd_a_x0", 32'(forward_a_e), 32'(2'b00));
      chk("fwd_b_w6", 32'(forward_b_e), 32'(2'b01));
      step();
      idle();

      // Load-use via rs2
      result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
      @(negedge clk);
      chk("lu_ctl", 32'(ctl), 32'(CTL_LU));
      chk_counters("lu_before");
      step(); exp_stall = 1;
      idle();
      @(negedge clk);
      chk("lu_after_ctl", 32'(ctl), 32'(CTL_IDLE));
      chk_counters("lu_after");
      step();
      result_src_e = 2'b01; rd_e = 5'd0;
      @(negedge clk);
      chk("lu_rd0", 32'(ctl), 32'(CTL_IDLE));
      step();
      result_src_e = 2'b10; rd_e = 5'd3; rs1_d = 5'd3;
      @(negedge clk);
      chk("lu_not_load", 32'(ctl), 32'(CTL_IDLE));
      step();
      result_src_e = 2'b01;
      @(negedge clk);
      chk("lu_rs1", 32'(ctl), 32'(CTL_LU));
      step(); exp_stall = 2;
      idle();

      // Branch alone, then branch with simultaneous load-use
      pc_src_e = 1'b1;
      @(negedge clk);
      chk("br_ctl", 32'(ctl), 32'(CTL_BR));
      step(); exp_flush = 1;
      result_src_e = 2'b01; rd_e = 5'd9; rs1_d = 5'd9;
      @(negedge clk);
      chk("br_lu_ctl", 32'(ctl), 32'(CTL_BR));
      chk_counters("br1");
      step(); exp_flush = 2;
      idle();

      // Memory wait of 3 not-ready cycles with branch held
      mem_access_m = 1'b1; pc_src_e = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mw_stall%0d", i), 32'(ctl), 32'(CTL_MS));
         step(); exp_stall++;
      end
      dmem_ready = 1'b1;
      @(negedge clk);
      chk("mw_ready_ctl", 32'(ctl), 32'(CTL_BR));
      step(); exp_flush++;
      idle();
      @(negedge clk);
      chk("mw_back_run", 32'(ctl), 32'(CTL_IDLE));
      chk_counters("mw");
      step();

      // Back-to-back accesses
      mem_access_m = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      chk("b2b_s1", 32'(ctl), 32'(CTL_MS));
      step(); exp_stall++;
      dmem_ready = 1'b1;
      @(negedge clk);
      chk("b2b_r1", 32'(ctl), 32'(CTL_IDLE));
      step();
      dmem_ready = 1'b0;
      @(negedge clk);
      chk("b2b_s2", 32'(ctl), 32'(CTL_MS));
      step(); exp_stall++;
      dmem_ready = 1'b1;
      @(negedge clk);
      chk("b2b_r2", 32'(ctl), 32'(CTL_IDLE));
      step();
      idle();
      @(negedge clk);
      chk_counters("b2b");
      step();

      // Saturation of stall counter at 15
      result_src_e = 2'b01; rd_e = 5'd4; rs2_d = 5'd4;
      for (int i = 0; i < 10; i++) step();
      exp_stall = 15;
      idle();
      @(negedge clk);
      chk_counters("sat");
      step();

      // Timeout: 4 stalled cycles, fault on the 4th edge
      mem_access_m = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("to_ctl%0d", i), 32'(ctl), 32'(CTL_MS));
         chk($sformatf("to_fault%0d", i), 32'(mem_fault), 32'd0);
         step();
      end
      idle();
      dmem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("flt_ctl%0d", i), 32'(ctl), 32'(CTL_MS));
         chk($sformatf("flt_sticky%0d", i), 32'(mem_fault), 32'd1);
         step();
      end

      // Reset while in FAULT
      rst = 1'b1;
      @(negedge clk);
      chk("rst_flt_ctl", 32'(ctl), 32'(CTL_RST));
      step();
      rst = 1'b0; idle(); exp_stall = 0; exp_flush = 0;
      @(negedge clk);
      chk("rst_flt_run", 32'(ctl), 32'(CTL_IDLE));
      chk("rst_flt_fault", 32'(mem_fault), 32'd0);
      chk_counters("rst_flt");
      step();

      // Reset in the middle of MEM_WAIT
      mem_access_m = 1'b1; dmem_ready = 1'b0;
      step();
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mw_ctl", 32'(ctl), 32'(CTL_RST));
      step();
      rst = 1'b0; idle();
      @(negedge clk);
      chk("rst_mw_run", 32'(ctl), 32'(CTL_IDLE));
      chk("rst_mw_fault", 32'(mem_fault), 32'd0);
      chk_counters("rst_mw");
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
